// File: rtl/period_gen_pkg.sv
// Shared types and config helpers for the phase-accumulator period generator.
package period_gen_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    // Helpers use a fixed wide argument so they serve any WIDTH up to 63.
    localparam int unsigned FN_W = 64;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    function automatic logic cfg_legal(input logic [FN_W-1:0] period,
                                       input logic [FN_W-1:0] clk_period);
        return (period == '0) || (period >= (clk_period << 1));
    endfunction

    function automatic logic [FN_W-1:0] clamp_high(input logic [FN_W-1:0] high,
                                                   input logic [FN_W-1:0] period);
        return (high > period) ? period : high;
    endfunction

endpackage

// File: rtl/period_gen_acc.sv
// Phase accumulator: advances by one reference period per step and reports the wrap.
module period_gen_acc
    import period_gen_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_1000 = 10000,
    parameter int unsigned WIDTH           = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_period,
    output logic             o_wrap,
    output logic [WIDTH-1:0] o_acc_next
);

    localparam logic [WIDTH:0] INC = (WIDTH+1)'(CLK_PERIOD_1000);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_sum      = {1'b0, r_acc} + INC;
        o_wrap     = (w_sum >= {1'b0, i_period});
        o_acc_next = WIDTH'(o_wrap ? (w_sum - {1'b0, i_period}) : w_sum);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_step) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/period_gen.sv
// Period/high-time waveform generator with handshaked config applied at period boundaries.
module period_gen
    import period_gen_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_1000 = 10000,
    parameter int unsigned WIDTH           = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwrdwn,
    input  logic             i_cfg_valid,
    output logic             o_cfg_ready,
    input  logic [WIDTH-1:0] i_cfg_period_1000,
    input  logic [WIDTH-1:0] i_cfg_high_1000,
    output logic             o_cfg_err,
    output logic             o_gen_out,
    output logic             o_period_start,
    output logic             o_running
);

    state_e           r_state;
    logic [WIDTH-1:0] r_period_act;
    logic [WIDTH-1:0] r_high_act;
    logic [WIDTH-1:0] r_pend_period;
    logic [WIDTH-1:0] r_pend_high;
    logic             r_pend_full;
    logic             r_cfg_err;
    logic             r_gen_out;
    logic             r_period_start;
    logic             r_running;

    logic             w_xfer;
    logic             w_legal;
    logic             w_accept;
    logic [WIDTH-1:0] w_cfg_high;
    logic             w_step;
    logic             w_wrap;
    logic             w_wrap_take;
    logic             w_stop;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_period_next;
    logic [WIDTH-1:0] w_high_next;

    assign o_cfg_ready    = !r_pend_full && !i_pwrdwn;
    assign o_cfg_err      = r_cfg_err;
    assign o_gen_out      = r_gen_out;
    assign o_period_start = r_period_start;
    assign o_running      = r_running;

    assign w_xfer     = i_cfg_valid && o_cfg_ready;
    assign w_legal    = cfg_legal(FN_W'(i_cfg_period_1000), FN_W'(CLK_PERIOD_1000));
    assign w_accept   = w_xfer && w_legal;
    assign w_cfg_high = WIDTH'(clamp_high(FN_W'(i_cfg_high_1000), FN_W'(i_cfg_period_1000)));

    // r_running low while in RUN marks the entry cycle, which restarts the phase at 0.
    assign w_step        = (r_state == RUN) && r_running && !i_pwrdwn;
    assign w_wrap_take   = w_step && w_wrap;
    assign w_period_next = (w_wrap_take && r_pend_full) ? r_pend_period : r_period_act;
    assign w_high_next   = (w_wrap_take && r_pend_full) ? r_pend_high : r_high_act;
    assign w_stop        = w_wrap_take && (w_period_next == '0);

    period_gen_acc #(
        .CLK_PERIOD_1000 (CLK_PERIOD_1000),
        .WIDTH           (WIDTH)
    ) u_acc (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (!w_step || w_stop),
        .i_step     (w_step),
        .i_period   (r_period_act),
        .o_wrap     (w_wrap),
        .o_acc_next (w_acc_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= IDLE;
            r_period_act   <= '0;
            r_high_act     <= '0;
            r_pend_period  <= '0;
            r_pend_high    <= '0;
            r_pend_full    <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_gen_out      <= 1'b0;
            r_period_start <= 1'b0;
            r_running      <= 1'b0;
        end else begin
            r_cfg_err      <= w_xfer && !w_legal;
            r_period_start <= 1'b0;
            if (i_pwrdwn) begin
                r_state     <= IDLE;
                r_gen_out   <= 1'b0;
                r_running   <= 1'b0;
                r_pend_full <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_gen_out <= 1'b0;
                        r_running <= 1'b0;
                        if (w_accept) begin
                            r_period_act <= i_cfg_period_1000;
                            r_high_act   <= w_cfg_high;
                        end
                        if (w_accept ? (i_cfg_period_1000 != '0) : (r_period_act != '0)) begin
                            r_state <= RUN;
                        end
                    end
                    RUN: begin
                        if (w_accept) begin
                            r_pend_period <= i_cfg_period_1000;
                            r_pend_high   <= w_cfg_high;
                            r_pend_full   <= 1'b1;
                        end
                        if (!r_running) begin
                            r_running      <= 1'b1;
                            r_period_start <= 1'b1;
                            r_gen_out      <= (r_high_act != '0);
                        end else begin
                            if (w_wrap) begin
                                r_period_start <= 1'b1;
                                if (r_pend_full) begin
                                    r_period_act <= r_pend_period;
                                    r_high_act   <= r_pend_high;
                                    r_pend_full  <= 1'b0;
                                end
                            end
                            if (w_stop) begin
                                r_state   <= IDLE;
                                r_gen_out <= 1'b0;
                                r_running <= 1'b0;
                            end else begin
                                r_gen_out <= (w_acc_next < w_high_next);
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_period_gen.sv
// Directed bench for period_gen with a 10 ns reference clock (CLK_PERIOD_1000 = 10000).
module tb_period_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwrdwn;
    logic        cfg_valid;
    logic [31:0] cfg_period;
    logic [31:0] cfg_high;
    logic        cfg_ready;
    logic        cfg_err;
    logic        gen_out;
    logic        period_start;
    logic        running;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    period_gen #(
        .CLK_PERIOD_1000 (10000),
        .WIDTH           (32)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_pwrdwn          (pwrdwn),
        .i_cfg_valid       (cfg_valid),
        .o_cfg_ready       (cfg_ready),
        .i_cfg_period_1000 (cfg_period),
        .i_cfg_high_1000   (cfg_high),
        .o_cfg_err         (cfg_err),
        .o_gen_out         (gen_out),
        .o_period_start    (period_start),
        .o_running         (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    // Advance one clock, then check gen_out and period_start.
    task automatic cyc(input string tag, input logic g, input logic ps);
        tick();
        chk1({tag, ".gen"}, gen_out, g);
        chk1({tag, ".ps"}, period_start, ps);
    endtask

    task automatic offer(input logic [31:0] p, input logic [31:0] h);
        cfg_valid  = 1'b1;
        cfg_period = p;
        cfg_high   = h;
    endtask

    initial begin
        rst_n      = 1'b0;
        pwrdwn     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_high   = '0;
        #2;
        chk1("rst.gen", gen_out, 1'b0);
        chk1("rst.ps", period_start, 1'b0);
        chk1("rst.run", running, 1'b0);
        chk1("rst.err", cfg_err, 1'b0);
        chk1("rst.rdy", cfg_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk1("idle.gen", gen_out, 1'b0);
        chk1("idle.run", running, 1'b0);

        // 40000/20000 from IDLE: entry one clk after acceptance, then 1,1,0,0.
        offer(32'd40000, 32'd20000);
        tick();
        cfg_valid = 1'b0;
        chk1("t1.acc.run", running, 1'b0);
        chk1("t1.acc.gen", gen_out, 1'b0);
        cyc("t1.entry", 1'b1, 1'b1);
        chk1("t1.entry.run", running, 1'b1);
        check("t1.entry.acc", dut.u_acc.r_acc, 32'd0);
        cyc("t1.c2", 1'b1, 1'b0);
        cyc("t1.c3", 1'b0, 1'b0);
        cyc("t1.c4", 1'b0, 1'b0);
        cyc("t1.c5", 1'b1, 1'b1);
        cyc("t1.c6", 1'b1, 1'b0);
        cyc("t1.c7", 1'b0, 1'b0);
        cyc("t1.c8", 1'b0, 1'b0);
        cyc("t1.c9", 1'b1, 1'b1);

        // Mid-period offer of 60000/10000 waits in pending until the wrap.
        cyc("t3.c10", 1'b1, 1'b0);
        offer(32'd60000, 32'd10000);
        chk1("t3.rdy.pre", cfg_ready, 1'b1);
        cyc("t3.c11", 1'b0, 1'b0);
        cfg_valid = 1'b0;
        chk1("t3.rdy.held", cfg_ready, 1'b0);
        cyc("t3.c12", 1'b0, 1'b0);
        chk1("t3.rdy.held2", cfg_ready, 1'b0);
        cyc("t3.wrap", 1'b1, 1'b1);
        chk1("t3.rdy.post", cfg_ready, 1'b1);
        check("t3.wrap.acc", dut.u_acc.r_acc, 32'd0);
        for (int i = 0; i < 5; i++) cyc("t3.low", 1'b0, 1'b0);
        cyc("t3.wrap2", 1'b1, 1'b1);

        // 25000/12500: fractional period, acc 0,10000,20000,5000,15000,0.
        offer(32'd25000, 32'd12500);
        cyc("t2.c20", 1'b0, 1'b0);
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) cyc("t2.old", 1'b0, 1'b0);
        cyc("t2.load", 1'b1, 1'b1);
        check("t2.acc0", dut.u_acc.r_acc, 32'd0);
        cyc("t2.c26", 1'b1, 1'b0);
        check("t2.acc1", dut.u_acc.r_acc, 32'd10000);
        cyc("t2.c27", 1'b0, 1'b0);
        check("t2.acc2", dut.u_acc.r_acc, 32'd20000);
        cyc("t2.c28", 1'b1, 1'b1);
        check("t2.acc3", dut.u_acc.r_acc, 32'd5000);
        cyc("t2.c29", 1'b0, 1'b0);
        check("t2.acc4", dut.u_acc.r_acc, 32'd15000);
        cyc("t2.c30", 1'b1, 1'b1);
        check("t2.acc5", dut.u_acc.r_acc, 32'd0);

        // Period 15000 is below two reference periods: rejected, nothing changes.
        offer(32'd15000, 32'd5000);
        cyc("t4.c31", 1'b1, 1'b0);
        cfg_valid = 1'b0;
        chk1("t4.err", cfg_err, 1'b1);
        chk1("t4.rdy", cfg_ready, 1'b1);
        cyc("t4.c32", 1'b0, 1'b0);
        chk1("t4.err.clr", cfg_err, 1'b0);
        cyc("t4.c33", 1'b1, 1'b1);

        // High 50000 > period 40000 clamps to a constant-high output.
        offer(32'd40000, 32'd50000);
        cyc("t5.c34", 1'b0, 1'b0);
        cfg_valid = 1'b0;
        cyc("t5.load", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("t5.hi", 1'b1, 1'b0);
        cyc("t5.wrap", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("t5.hi2", 1'b1, 1'b0);
        cyc("t5.wrap2", 1'b1, 1'b1);

        // Back to 40000/20000, then power down mid-high with a pending config.
        offer(32'd40000, 32'd20000);
        cyc("t6.c44", 1'b1, 1'b0);
        cfg_valid = 1'b0;
        cyc("t6.c45", 1'b1, 1'b0);
        cyc("t6.c46", 1'b1, 1'b0);
        cyc("t6.load", 1'b1, 1'b1);
        offer(32'd60000, 32'd30000);
        cyc("t6.c48", 1'b1, 1'b0);
        cfg_valid = 1'b0;
        chk1("t6.pend.rdy", cfg_ready, 1'b0);
        pwrdwn = 1'b1;
        #1;
        chk1("t6.pd.rdy", cfg_ready, 1'b0);
        cyc("t6.pd1", 1'b0, 1'b0);
        chk1("t6.pd1.run", running, 1'b0);
        check("t6.pd1.acc", dut.u_acc.r_acc, 32'd0);
        cyc("t6.pd2", 1'b0, 1'b0);
        pwrdwn = 1'b0;
        #1;
        chk1("t6.pend.clr", cfg_ready, 1'b1);
        cyc("t6.idle", 1'b0, 1'b0);
        chk1("t6.idle.run", running, 1'b0);
        cyc("t6.entry", 1'b1, 1'b1);
        chk1("t6.entry.run", running, 1'b1);
        cyc("t6.c53", 1'b1, 1'b0);
        cyc("t6.c54", 1'b0, 1'b0);
        cyc("t6.c55", 1'b0, 1'b0);
        cyc("t6.c56", 1'b1, 1'b1);

        // Period 0 in RUN stops the generator at the next wrap.
        offer(32'd0, 32'd0);
        cyc("t7.c57", 1'b1, 1'b0);
        cfg_valid = 1'b0;
        cyc("t7.c58", 1'b0, 1'b0);
        cyc("t7.c59", 1'b0, 1'b0);
        tick();
        chk1("t7.stop.gen", gen_out, 1'b0);
        chk1("t7.stop.run", running, 1'b0);
        cyc("t7.idle", 1'b0, 1'b0);
        chk1("t7.idle.run", running, 1'b0);
        check("t7.idle.acc", dut.u_acc.r_acc, 32'd0);

        // Asynchronous reset while running high with a pending config.
        offer(32'd40000, 32'd20000);
        tick();
        cfg_valid = 1'b0;
        chk1("t8.acc.run", running, 1'b0);
        cyc("t8.entry", 1'b1, 1'b1);
        offer(32'd60000, 32'd10000);
        cyc("t8.c64", 1'b1, 1'b0);
        cfg_valid = 1'b0;
        chk1("t8.rdy.held", cfg_ready, 1'b0);
        chk1("t8.run", running, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("t8.rst.gen", gen_out, 1'b0);
        chk1("t8.rst.run", running, 1'b0);
        chk1("t8.rst.ps", period_start, 1'b0);
        chk1("t8.rst.err", cfg_err, 1'b0);
        chk1("t8.rst.rdy", cfg_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        cyc("t8.after", 1'b0, 1'b0);
        chk1("t8.after.run", running, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
